// File: rtl/address_ram_map_if.sv
// Step/address-map bundle between the layer controller and the RAM address-map decoder.
interface address_ram_map_if;
  logic [4:0]  step;
  logic        re_ram;
  logic [12:0] firstaddr;
  logic [12:0] lastaddr;

  modport master (
    output step,
    input  re_ram,
    input  firstaddr,
    input  lastaddr
  );

  modport slave (
    input  step,
    output re_ram,
    output firstaddr,
    output lastaddr
  );
endinterface

// File: rtl/address_ram_map.sv
// Registered decoder from layer step to the inclusive address range of that step's block
// in the 13-bit weight/pixel RAM, plus a read-enable flag.
module address_ram_map #(
  parameter int unsigned picture_size     = 28,
  parameter int unsigned convolution_size = 9,
  parameter int unsigned N_IN             = 1,
  parameter int unsigned N1               = 4,
  parameter int unsigned N2               = 4,
  parameter int unsigned N3               = 8,
  parameter int unsigned N4               = 8,
  parameter int unsigned N5               = 16,
  parameter int unsigned N6               = 16,
  parameter int unsigned DENSE_IN         = 16,
  parameter int unsigned DENSE_OUT        = 10
) (
  input logic              clk,
  input logic              rst_n,
  address_ram_map_if.slave bus
);

  localparam int unsigned Pic = picture_size * picture_size;
  localparam int unsigned W1  = convolution_size * N_IN * N1;
  localparam int unsigned W2  = convolution_size * N1 * N2;
  localparam int unsigned W3  = convolution_size * N2 * N3;
  localparam int unsigned W4  = convolution_size * N3 * N4;
  localparam int unsigned W5  = convolution_size * N4 * N5;
  localparam int unsigned W6  = convolution_size * N5 * N6;
  localparam int unsigned Wd  = DENSE_IN * DENSE_OUT;

  // Blocks packed back to back from address 0.
  localparam int unsigned B0 = 0;
  localparam int unsigned B1 = B0 + Pic;
  localparam int unsigned B2 = B1 + W1;
  localparam int unsigned B3 = B2 + W2;
  localparam int unsigned B4 = B3 + W3;
  localparam int unsigned B5 = B4 + W4;
  localparam int unsigned B6 = B5 + W5;
  localparam int unsigned B7 = B6 + W6;
  localparam int unsigned MapEnd = B7 + Wd;

  if (MapEnd > 8192) begin : g_map_overflow
    $error("address_ram_map: blocks need %0d words, RAM holds 8192", MapEnd);
  end

  logic        re_d, re_q;
  logic [12:0] first_d, first_q;
  logic [12:0] last_d, last_q;

  always_comb begin
    re_d    = 1'b0;
    first_d = '0;
    last_d  = '0;
    case (bus.step)
      5'd1:  begin re_d = 1'b1; first_d = 13'(B0); last_d = 13'(B0 + Pic - 1); end
      5'd2:  begin re_d = 1'b1; first_d = 13'(B1); last_d = 13'(B1 + W1 - 1);  end
      5'd4:  begin re_d = 1'b1; first_d = 13'(B2); last_d = 13'(B2 + W2 - 1);  end
      5'd6:  begin re_d = 1'b1; first_d = 13'(B3); last_d = 13'(B3 + W3 - 1);  end
      5'd8:  begin re_d = 1'b1; first_d = 13'(B4); last_d = 13'(B4 + W4 - 1);  end
      5'd10: begin re_d = 1'b1; first_d = 13'(B5); last_d = 13'(B5 + W5 - 1);  end
      5'd12: begin re_d = 1'b1; first_d = 13'(B6); last_d = 13'(B6 + W6 - 1);  end
      5'd14: begin re_d = 1'b1; first_d = 13'(B7); last_d = 13'(B7 + Wd - 1);  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q    <= 1'b0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      re_q    <= re_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign bus.re_ram    = re_q;
  assign bus.firstaddr = first_q;
  assign bus.lastaddr  = last_q;

endmodule

// File: tb/tb_address_ram_map.sv
// Bench for address_ram_map: default map plus a picture_size=8 instance, directed and random steps
// checked against a block-size/running-sum reference model.
module tb_address_ram_map;

  logic       clk;
  logic       rst_n;
  logic [4:0] step_drv;
  int         n_assert;
  int         n_fail;

  address_ram_map_if bus_a ();
  address_ram_map_if bus_b ();

  assign bus_a.step = step_drv;
  assign bus_b.step = step_drv;

  address_ram_map u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  address_ram_map #(
    .picture_size (8)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sizes of the eight blocks in order, base = sum of all earlier sizes.
  function automatic void model(input int unsigned ps, input int unsigned st, output logic re,
                                output logic [12:0] f, output logic [12:0] l);
    int unsigned sz[8];
    int unsigned nf[7];
    int unsigned base;
    int          idx;
    nf[0] = 1; nf[1] = 4; nf[2] = 4; nf[3] = 8; nf[4] = 8; nf[5] = 16; nf[6] = 16;
    sz[0] = ps * ps;
    for (int k = 1; k <= 6; k++) sz[k] = 9 * nf[k-1] * nf[k];
    sz[7] = 16 * 10;
    idx = -1;
    if (st == 1) idx = 0;
    else if (st >= 2 && st <= 14 && (st % 2) == 0) idx = int'(st / 2);
    re = 1'b0;
    f  = '0;
    l  = '0;
    if (idx >= 0) begin
      base = 0;
      for (int k = 0; k < idx; k++) base += sz[k];
      re = 1'b1;
      f  = 13'(base);
      l  = 13'(base + sz[idx] - 1);
    end
  endfunction

  task automatic chk1(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compare both instances against the model for step st.
  task automatic check(input string tag, input int unsigned st);
    logic        re;
    logic [12:0] f, l;
    model(28, st, re, f, l);
    chk1({tag, " a.re"},    13'(bus_a.re_ram), 13'(re));
    chk1({tag, " a.first"}, bus_a.firstaddr, f);
    chk1({tag, " a.last"},  bus_a.lastaddr, l);
    model(8, st, re, f, l);
    chk1({tag, " b.re"},    13'(bus_b.re_ram), 13'(re));
    chk1({tag, " b.first"}, bus_b.firstaddr, f);
    chk1({tag, " b.last"},  bus_b.lastaddr, l);
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, " a.re"},    13'(bus_a.re_ram), 13'd0);
    chk1({tag, " a.first"}, bus_a.firstaddr, 13'd0);
    chk1({tag, " a.last"},  bus_a.lastaddr, 13'd0);
    chk1({tag, " b.re"},    13'(bus_b.re_ram), 13'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned prev;
    int unsigned st;
    int unsigned seq[4];
    int unsigned idle[6];
    n_assert = 0;
    n_fail   = 0;

    // Reset asserted with step 1 -> outputs clear immediately.
    step_drv = 5'd1;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    tick();
    check_zero("reset_held");
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("step1", 1);

    // Absolute spot checks of the default map.
    step_drv = 5'd2;  tick(); check("step2", 2);
    chk1("step2 abs first", bus_a.firstaddr, 13'd784);
    chk1("step2 abs last",  bus_a.lastaddr, 13'd819);
    chk1("pic8 first",      bus_b.firstaddr, 13'd64);
    step_drv = 5'd12; tick(); check("step12", 12);
    chk1("step12 abs last", bus_a.lastaddr, 13'd5283);
    step_drv = 5'd14; tick(); check("step14", 14);
    chk1("step14 abs first", bus_a.firstaddr, 13'd5284);
    chk1("step14 abs last",  bus_a.lastaddr, 13'd5443);

    idle[0] = 0; idle[1] = 3; idle[2] = 5; idle[3] = 13; idle[4] = 15; idle[5] = 31;
    for (int i = 0; i < 6; i++) begin
      step_drv = 5'(idle[i]);
      tick();
      check("idle", idle[i]);
    end

    // Back to back: before each edge the outputs still reflect the previous step.
    seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 4;
    prev = 31;
    for (int i = 0; i < 4; i++) begin
      step_drv = 5'(seq[i]);
      #1 check("latency_hold", prev);
      tick();
      check("b2b", seq[i]);
      prev = seq[i];
    end

    // Async reset between edges during step 10.
    step_drv = 5'd10; tick(); check("step10", 10);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    #2 rst_n = 1'b1;
    tick(); check("after_rst", 10);

    // Random steps, one per cycle.
    for (int i = 0; i < 300; i++) begin
      st = $urandom_range(0, 31);
      step_drv = 5'(st);
      tick();
      check("rand", st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
